// File: rtl/axi4lite_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi4lite_rd_arbiter                                             |
// | Purpose  : Round-robin arbiter that serialises two AXI4-Lite read          |
// |            requesters onto one shared read path, one transaction at a time.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst_n                 clock, asynchronous active-low reset          |
// |   m0_* / m1_*                requester AR (in) and R (out) channels        |
// |   s_araddr_o/s_arvalid_o     shared AR channel (address from register)     |
// |   s_arready_i                shared AR ready                               |
// |   s_rdata_i/s_rresp_i        shared R data and response                    |
// |   s_rvalid_i/s_rready_o      shared R handshake                            |
// +----------------------------------------------------------------------------+
// | Build option                                                               |
// |   AXI4LITE_RD_ARB_TIMEOUT_EN : when defined, a response that does not      |
// |   arrive within TIMEOUT_CYCLES RESP cycles is answered with SLVERR and the |
// |   late beat is drained from the shared path.                               |
// +----------------------------------------------------------------------------+
module axi4lite_rd_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // requester 0
   input  logic [ADDR_WIDTH-1:0] m0_araddr_i,
   input  logic                  m0_arvalid_i,
   output logic                  m0_arready_o,
   output logic [DATA_WIDTH-1:0] m0_rdata_o,
   output logic [1:0]            m0_rresp_o,
   output logic                  m0_rvalid_o,
   input  logic                  m0_rready_i,
   // requester 1
   input  logic [ADDR_WIDTH-1:0] m1_araddr_i,
   input  logic                  m1_arvalid_i,
   output logic                  m1_arready_o,
   output logic [DATA_WIDTH-1:0] m1_rdata_o,
   output logic [1:0]            m1_rresp_o,
   output logic                  m1_rvalid_o,
   input  logic                  m1_rready_i,
   // shared read path
   output logic [ADDR_WIDTH-1:0] s_araddr_o,
   output logic                  s_arvalid_o,
   input  logic                  s_arready_i,
   input  logic [DATA_WIDTH-1:0] s_rdata_i,
   input  logic [1:0]            s_rresp_i,
   input  logic                  s_rvalid_i,
   output logic                  s_rready_o
);

   // Out-of-range timeout values are rejected at elaboration.
   if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("axi4lite_rd_arbiter: TIMEOUT_CYCLES must be within 2..65535");
   end

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_RESP  = 3'd2,
      ST_ERR   = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   localparam logic [1:0] c_resp_slverr = 2'b10;

   state_t                  state_q, state_d;
   logic                    grant_q, grant_d;          // owner of the open transaction
   logic                    last_grant_q, last_grant_d; // owner of the last completed one
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
   localparam logic [15:0] c_tmo_limit = 16'(TIMEOUT_CYCLES);
   logic [15:0]             tmo_cnt_q, tmo_cnt_d;
   logic [15:0]             w_tmo_cnt_inc;
   assign w_tmo_cnt_inc = tmo_cnt_q + 16'd1;
`endif

   logic                    w_any_req;
   logic                    w_pick;       // 1 selects m1
   logic                    w_sel_rready; // rready of the granted requester
   logic                    w_rvalid;
   logic [DATA_WIDTH-1:0]   w_rdata;
   logic [1:0]              w_rresp;

   assign w_any_req    = m0_arvalid_i | m1_arvalid_i;
   // On contention the requester that did not complete last wins; otherwise the
   // only requester present wins.
   assign w_pick       = (m0_arvalid_i && m1_arvalid_i) ? ~last_grant_q : m1_arvalid_i;
   assign w_sel_rready = grant_q ? m1_rready_i : m0_rready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
         tmo_cnt_q    <= 16'd0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
`endif
      m0_arready_o = 1'b0;
      m1_arready_o = 1'b0;
      s_arvalid_o  = 1'b0;
      s_rready_o   = 1'b0;
      w_rvalid     = 1'b0;
      w_rdata      = '0;
      w_rresp      = 2'b00;

      case (state_q)
         ST_IDLE: begin
            if (w_any_req) begin
               // The grant is visible combinationally, so it is masked while the
               // asynchronous reset is held to keep every output low in reset.
               m0_arready_o = rst_n & ~w_pick;
               m1_arready_o = rst_n &  w_pick;
               grant_d      = w_pick;
               addr_d       = w_pick ? m1_araddr_i : m0_araddr_i;
               state_d      = ST_ADDR;
            end
         end

         ST_ADDR: begin
            s_arvalid_o = 1'b1;
            if (s_arready_i) begin
               state_d = ST_RESP;
`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
               tmo_cnt_d = 16'd0;
`endif
            end
         end

         ST_RESP: begin
            w_rvalid   = s_rvalid_i;
            w_rdata    = s_rdata_i;
            w_rresp    = s_rresp_i;
            s_rready_o = w_sel_rready;
            if (s_rvalid_i && w_sel_rready) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end
`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
            // A beat stalled by the requester is not a timeout: count only
            // cycles in which the shared path has not produced data.
            else if (!s_rvalid_i) begin
               tmo_cnt_d = w_tmo_cnt_inc;
               if (w_tmo_cnt_inc == c_tmo_limit) begin
                  state_d = ST_ERR;
               end
            end
`endif
         end

`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
         ST_ERR: begin
            w_rvalid = 1'b1;
            w_rresp  = c_resp_slverr;
            if (w_sel_rready) begin
               last_grant_d = grant_q;
               state_d      = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // Swallow the late beat so it can never reach the next requester.
            s_rready_o = 1'b1;
            if (s_rvalid_i) begin
               state_d = ST_IDLE;
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Steer the selected response to the granted requester only.
   assign m0_rvalid_o = w_rvalid & ~grant_q;
   assign m1_rvalid_o = w_rvalid &  grant_q;
   assign m0_rdata_o  = grant_q ? '0 : w_rdata;
   assign m1_rdata_o  = grant_q ? w_rdata : '0;
   assign m0_rresp_o  = grant_q ? 2'b00 : w_rresp;
   assign m1_rresp_o  = grant_q ? w_rresp : 2'b00;

   assign s_araddr_o  = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axi4lite_rd_arbiter                                          |
// | Purpose  : Self-checking bench for axi4lite_rd_arbiter: directed scenarios |
// |            with literal expectations plus randomized traffic compared     |
// |            each cycle against a transaction-level model.                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_axi4lite_rd_arbiter;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
   logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;
   logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
   logic [1:0]    m0_rresp, m1_rresp, s_rresp;
   logic          m0_rvalid, m1_rvalid, m0_rready, m1_rready;
   logic          s_arvalid, s_arready, s_rvalid, s_rready;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   axi4lite_rd_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_araddr_i(m0_araddr), .m0_arvalid_i(m0_arvalid), .m0_arready_o(m0_arready),
      .m0_rdata_o(m0_rdata), .m0_rresp_o(m0_rresp), .m0_rvalid_o(m0_rvalid), .m0_rready_i(m0_rready),
      .m1_araddr_i(m1_araddr), .m1_arvalid_i(m1_arvalid), .m1_arready_o(m1_arready),
      .m1_rdata_o(m1_rdata), .m1_rresp_o(m1_rresp), .m1_rvalid_o(m1_rvalid), .m1_rready_i(m1_rready),
      .s_araddr_o(s_araddr), .s_arvalid_o(s_arvalid), .s_arready_i(s_arready),
      .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rvalid_i(s_rvalid), .s_rready_o(s_rready)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", nm, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   // Transaction view: is a read open, who owns it, has its address gone out,
   // is an error response owed, is a late beat still to be swallowed.
   logic          m_busy = 1'b0, m_owner = 1'b0, m_acc = 1'b0;
   logic          m_err = 1'b0, m_drain = 1'b0, m_last = 1'b1;
   logic [AW-1:0] m_addr = '0;
   int            m_wait = 0;

   always @(negedge clk) begin : p_compare
      logic          arv[2], rdy[2], e_arready[2], e_rvalid[2];
      logic [AW-1:0] adr[2];
      logic [DW-1:0] e_rdata[2];
      logic [1:0]    e_rresp[2];
      logic          e_sarvalid, e_srready, win;
      int            o;

      arv[0] = m0_arvalid;  arv[1] = m1_arvalid;
      rdy[0] = m0_rready;   rdy[1] = m1_rready;
      adr[0] = m0_araddr;   adr[1] = m1_araddr;
      for (int k = 0; k < 2; k++) begin
         e_arready[k] = 1'b0; e_rvalid[k] = 1'b0; e_rdata[k] = '0; e_rresp[k] = 2'b00;
      end
      e_sarvalid = 1'b0;
      e_srready  = 1'b0;
      win        = 1'b0;
      o          = int'(m_owner);

      if (!rst_n) begin
         m_busy = 1'b0; m_acc = 1'b0; m_err = 1'b0; m_drain = 1'b0;
         m_last = 1'b1; m_addr = '0; m_wait = 0;
      end else if (!m_busy) begin
         if (arv[0] || arv[1]) begin
            win = (arv[0] && arv[1]) ? !m_last : arv[1];
            e_arready[int'(win)] = 1'b1;
         end
      end else if (!m_acc) begin
         e_sarvalid = 1'b1;
      end else if (m_err) begin
         e_rvalid[o] = 1'b1;
         e_rresp[o]  = 2'b10;
      end else if (m_drain) begin
         e_srready = 1'b1;
      end else begin
         e_rvalid[o] = s_rvalid;
         e_rdata[o]  = s_rdata;
         e_rresp[o]  = s_rresp;
         e_srready   = rdy[o];
      end

      chk("m0_arready", 64'(m0_arready), 64'(e_arready[0]));
      chk("m1_arready", 64'(m1_arready), 64'(e_arready[1]));
      chk("m0_rvalid",  64'(m0_rvalid),  64'(e_rvalid[0]));
      chk("m1_rvalid",  64'(m1_rvalid),  64'(e_rvalid[1]));
      chk("m0_rdata",   m0_rdata,        e_rdata[0]);
      chk("m1_rdata",   m1_rdata,        e_rdata[1]);
      chk("m0_rresp",   64'(m0_rresp),   64'(e_rresp[0]));
      chk("m1_rresp",   64'(m1_rresp),   64'(e_rresp[1]));
      chk("s_arvalid",  64'(s_arvalid),  64'(e_sarvalid));
      chk("s_araddr",   64'(s_araddr),   64'(m_addr));
      chk("s_rready",   64'(s_rready),   64'(e_srready));

      // advance the model across the coming rising edge
      if (rst_n) begin
         if (!m_busy) begin
            if (arv[0] || arv[1]) begin
               m_busy = 1'b1; m_owner = win; m_addr = adr[int'(win)]; m_acc = 1'b0;
            end
         end else if (!m_acc) begin
            if (s_arready) begin m_acc = 1'b1; m_wait = 0; end
         end else if (m_err) begin
            if (rdy[o]) begin m_err = 1'b0; m_drain = 1'b1; m_last = m_owner; end
         end else if (m_drain) begin
            if (s_rvalid) begin m_drain = 1'b0; m_busy = 1'b0; end
         end else if (s_rvalid && rdy[o]) begin
            m_busy = 1'b0; m_last = m_owner;
         end else if (!s_rvalid) begin
`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
            m_wait++;
            if (m_wait == TO) m_err = 1'b1;
`endif
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic at_neg();
      @(negedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      m0_araddr = '0; m1_araddr = '0; m0_arvalid = 1'b1; m1_arvalid = 1'b0;
      m0_rready = 1'b0; m1_rready = 1'b0;
      s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;

      // reset state, with a request pending to prove arready is held low
      at_neg();
      chk("rst_m0_arready", 64'(m0_arready), 64'd0);
      chk("rst_s_arvalid",  64'(s_arvalid),  64'd0);
      chk("rst_s_araddr",   64'(s_araddr),   64'd0);
      step(); rst_n = 1'b1; m0_arvalid = 1'b0;

      // single m0 read of 0x100
      step(); m0_arvalid = 1'b1; m0_araddr = 32'h100; s_arready = 1'b1; m0_rready = 1'b1;
      at_neg(); chk("rd_m0_arready", 64'(m0_arready), 64'd1); chk("rd_m1_arready", 64'(m1_arready), 64'd0);
      step(); m0_arvalid = 1'b0;
      at_neg(); chk("rd_s_arvalid", 64'(s_arvalid), 64'd1); chk("rd_s_araddr", 64'(s_araddr), 64'h100);
      step();
      at_neg(); chk("rd_resp_wait", 64'(m0_rvalid), 64'd0);
      step(); s_rvalid = 1'b1; s_rdata = 64'hDEADBEEF_CAFEF00D; s_rresp = 2'b00;
      at_neg();
      chk("rd_m0_rvalid", 64'(m0_rvalid), 64'd1);
      chk("rd_m0_rdata",  m0_rdata, 64'hDEADBEEF_CAFEF00D);
      chk("rd_m0_rresp",  64'(m0_rresp), 64'd0);
      chk("rd_m1_rvalid", 64'(m1_rvalid), 64'd0);
      chk("rd_m1_rdata",  m1_rdata, 64'd0);
      chk("rd_s_rready",  64'(s_rready), 64'd1);
      step(); s_rvalid = 1'b0;
      at_neg(); chk("rd_idle_s_rready", 64'(s_rready), 64'd0);

      // contention straight after reset: m0 first, then m1, then m0 again
      step(); rst_n = 1'b0;
      step(); rst_n = 1'b1;
      step(); m0_arvalid = 1'b1; m0_araddr = 32'h10; m1_arvalid = 1'b1; m1_araddr = 32'h20;
      at_neg(); chk("rr_first_m0", 64'(m0_arready), 64'd1); chk("rr_first_m1", 64'(m1_arready), 64'd0);
      step(); m0_arvalid = 1'b0;
      at_neg(); chk("rr_addr_0x10", 64'(s_araddr), 64'h10);
      step(); s_rvalid = 1'b1; s_rdata = 64'h1111;
      at_neg(); chk("rr_m0_rvalid", 64'(m0_rvalid), 64'd1); chk("rr_m1_rvalid_off", 64'(m1_rvalid), 64'd0);
      step(); s_rvalid = 1'b0;
      at_neg(); chk("rr_second_m1", 64'(m1_arready), 64'd1);
      step(); m1_arvalid = 1'b0; m1_rready = 1'b1;
      at_neg(); chk("rr_addr_0x20", 64'(s_araddr), 64'h20);
      step(); s_rvalid = 1'b1; s_rdata = 64'h2222;
      at_neg(); chk("rr_m1_rvalid", 64'(m1_rvalid), 64'd1); chk("rr_m0_rvalid_off", 64'(m0_rvalid), 64'd0);
      step(); s_rvalid = 1'b0;
      m0_arvalid = 1'b1; m0_araddr = 32'h30; m1_arvalid = 1'b1; m1_araddr = 32'h40;
      at_neg(); chk("rr_again_m0", 64'(m0_arready), 64'd1); chk("rr_again_m1", 64'(m1_arready), 64'd0);

      // shared AR stalled for five cycles
      step(); m0_arvalid = 1'b0; s_arready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         at_neg();
         chk("stall_s_arvalid", 64'(s_arvalid), 64'd1);
         chk("stall_s_araddr",  64'(s_araddr), 64'h30);
         chk("stall_arready",   64'({m0_arready, m1_arready}), 64'd0);
         step();
      end
      s_arready = 1'b1;
      at_neg(); chk("stall_release", 64'(s_arvalid), 64'd1);

      // requester back-pressure: three stalled cycles, transfer on the fourth
      step(); s_rvalid = 1'b1; s_rdata = 64'h0123_4567_89AB_CDEF; s_rresp = 2'b01; m0_rready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         at_neg();
         chk("bp_s_rready", 64'(s_rready), 64'd0);
         chk("bp_m0_rvalid", 64'(m0_rvalid), 64'd1);
         chk("bp_m0_rdata", m0_rdata, 64'h0123_4567_89AB_CDEF);
         step();
      end
      m0_rready = 1'b1;
      at_neg(); chk("bp_transfer", 64'(s_rready), 64'd1);
      step(); s_rvalid = 1'b0;
      at_neg(); chk("bp_next_m1", 64'(m1_arready), 64'd1); chk("bp_next_m0", 64'(m0_arready), 64'd0);

      // reset in the middle of a response wait
      step(); m1_arvalid = 1'b0;
      at_neg(); chk("rst_mid_addr", 64'(s_araddr), 64'h40);
      step();
      step(); rst_n = 1'b0; s_rvalid = 1'b1; m1_rready = 1'b1;
      #2;
      chk("rst_async_m1_rvalid", 64'(m1_rvalid), 64'd0);
      chk("rst_async_s_rready",  64'(s_rready), 64'd0);
      chk("rst_async_s_araddr",  64'(s_araddr), 64'd0);
      step(); rst_n = 1'b1;
      at_neg();
      chk("rst_late_m1_rvalid", 64'(m1_rvalid), 64'd0);
      chk("rst_late_m0_rvalid", 64'(m0_rvalid), 64'd0);
      step(); s_rvalid = 1'b0;

`ifdef AXI4LITE_RD_ARB_TIMEOUT_EN
      // response never arrives: SLVERR after TO cycles, late beat absorbed
      step(); m0_arvalid = 1'b1; m0_araddr = 32'h200; s_arready = 1'b1; m0_rready = 1'b0;
      at_neg(); chk("to_grant", 64'(m0_arready), 64'd1);
      step(); m0_arvalid = 1'b0;
      step();
      for (int k = 0; k < TO; k++) begin
         at_neg(); chk("to_waiting", 64'(m0_rvalid), 64'd0);
         step();
      end
      at_neg();
      chk("to_err_rvalid", 64'(m0_rvalid), 64'd1);
      chk("to_err_rresp",  64'(m0_rresp), 64'd2);
      chk("to_err_rdata",  m0_rdata, 64'd0);
      chk("to_err_srready", 64'(s_rready), 64'd0);
      step(); m0_rready = 1'b1;
      step(); m0_rready = 1'b0; m1_arvalid = 1'b1; m1_araddr = 32'h300;
      at_neg(); chk("to_drain_srready", 64'(s_rready), 64'd1); chk("to_drain_m1_arready", 64'(m1_arready), 64'd0);
      step(); s_rvalid = 1'b1; s_rdata = 64'hBAD;
      at_neg(); chk("to_drain_m0_rvalid", 64'(m0_rvalid), 64'd0); chk("to_drain_m1_rvalid", 64'(m1_rvalid), 64'd0);
      step(); s_rvalid = 1'b0;
      at_neg(); chk("to_next_grant", 64'(m1_arready), 64'd1);
      step(); m1_arvalid = 1'b0;
      at_neg(); chk("to_next_addr", 64'(s_araddr), 64'h300);
`endif

      // randomized traffic, checked every cycle by the model
      for (int i = 0; i < 4000; i++) begin
         step();
         rst_n      = ($urandom_range(0, 299) != 0);
         m0_arvalid = ($urandom_range(0, 1) != 0);
         m1_arvalid = ($urandom_range(0, 1) != 0);
         m0_araddr  = $urandom();
         m1_araddr  = $urandom();
         m0_rready  = ($urandom_range(0, 3) != 0);
         m1_rready  = ($urandom_range(0, 3) != 0);
         s_arready  = ($urandom_range(0, 1) != 0);
         s_rvalid   = ($urandom_range(0, 5) == 0);
         s_rdata    = {$urandom(), $urandom()};
         s_rresp    = 2'($urandom_range(0, 3));
      end
      step(); rst_n = 1'b1;
      at_neg();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi4lite_rd_arbiter.md
AXI4LITE_RD_ARBITER -- requirements
Module: axi4lite_rd_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all AR channels.
REQ-002 Parameter DATA_WIDTH, default 64, read data width of all R channels.
REQ-003 Parameter TIMEOUT_CYCLES, default 256, response-wait limit in clk cycles, legal range 2..65535.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 m0_araddr/m1_araddr  input  ADDR_WIDTH  requester read address.
REQ-007 m0_arvalid/m1_arvalid  input  1  requester address valid.
REQ-008 m0_arready/m1_arready  output  1  requester address accepted.
REQ-009 m0_rdata/m1_rdata  output  DATA_WIDTH  read data to requester.
REQ-010 m0_rresp/m1_rresp  output  2  read response to requester.
REQ-011 m0_rvalid/m1_rvalid  output  1  read data valid to requester.
REQ-012 m0_rready/m1_rready  input  1  requester read data ready.
REQ-013 s_araddr  output  ADDR_WIDTH  shared read-path address, driven from internal register.
REQ-014 s_arvalid/s_arready  output/input  1  shared read-path address handshake.
REQ-015 s_rdata/s_rresp  input  DATA_WIDTH/2  shared read-path data and response.
REQ-016 s_rvalid/s_rready  input/output  1  shared read-path data handshake.

Function
REQ-017 Block SHALL serialise two AXI4-Lite read requesters onto one shared read path, exactly one transaction outstanding at a time.
REQ-018 FSM states SHALL be IDLE, ADDR, RESP, ERR, DRAIN; ERR and DRAIN are reachable only under REQ-030.
REQ-019 IDLE: if any mX_arvalid=1, the SHALL assert winner's mX_arready combinationally that cycle, latch araddr and grant index g, and go to ADDR.
REQ-020 Arbitration SHALL be round-robin: with both arvalid high, winner is the master other than last_grant; with one high, that master wins.
REQ-021 last_grant SHALL update to g on completion of the R handshake, not at grant.
REQ-022 ADDR: s_arvalid=1 holding latched address stable; on s_arready=1 go to RESP next cycle.
REQ-023 RESP: mg_rvalid=s_rvalid, mg_rdata=s_rdata, mg_rresp=s_rresp, s_rready=mg_rready, all combinational; on s_rvalid&&s_rready go to IDLE.
REQ-024 Non-granted master SHALL see arready=0, rvalid=0, rdata=0, rresp=0 at all times.
REQ-025 arready SHALL be 0 for both masters in every state except IDLE; next grant earliest the cycle after return to IDLE.
REQ-026 Minimum latency: arvalid accepted cycle 0, s_arvalid high cycle 1, mg_rvalid follows s_rvalid with zero added delay.
REQ-027 Requester dropping arvalid before arready SHALL not be granted that cycle; no state retained for it.

Reset
REQ-028 On rst_n=0: state=IDLE, last_grant=1 (m0 wins first contention), address register=0, timeout counter=0, all outputs 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it immediately; no response is replayed after reset release.

Configuration
REQ-030 Macro AXI4LITE_RD_ARB_TIMEOUT_EN defined: 16-bit counter clears on entering RESP, increments each RESP cycle with s_rvalid=0; on reaching TIMEOUT_CYCLES go to ERR.
REQ-031 ERR: mg_rvalid=1, mg_rdata=0, mg_rresp=2'b10 (SLVERR), s_rready=0; on mg_rready=1 update last_grant, go to DRAIN.
REQ-032 DRAIN: s_rready=1, masters see no R activity; on s_rvalid=1 discard beat, go to IDLE.
REQ-033 Macro undefined: no counter, ERR/DRAIN absent, RESP waits indefinitely.

Verification
REQ-034 m0 read 0x100, s_arready=1 immediately, s_rvalid cycle 3 with rdata=0xDEADBEEF_CAFEF00D rresp=0 -> m0 receives same data/resp, m1 outputs stay 0.
REQ-035 m0 and m1 arvalid same cycle after reset, addresses 0x10/0x20 -> s_araddr 0x10 first, then 0x20; repeat contention -> m0 first again.
REQ-036 s_arready held 0 for 5 cycles -> s_arvalid stays 1, s_araddr stable, both arready stay 0.
REQ-037 mg_rready low 3 cycles while s_rvalid=1 -> s_rready low 3 cycles, data held, single transfer on 4th cycle.
REQ-038 With AXI4LITE_RD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no s_rvalid -> after 8 RESP cycles m0 gets rresp=2'b10 rdata=0; late s_rvalid absorbed; next grant proceeds.
REQ-039 rst_n pulsed low in RESP -> all outputs 0 asynchronously, state IDLE, late s_rvalid after release produces no mX_rvalid.
